action_decoder: RTL
===================

Name: action_decoder

Overview:
- Closes the loop of the hippocampal SNN agent.
- Integrates output-layer spikes over a fixed decision window and selects an action: stay or swap position.
- Issues the `change_InVec` pulse and the trial-end `trial_break` pulse that drive the position generator.
- Keeps the trial index `iTrial`, evaluates reward against a goal position, and enforces a per-trial step limit.

Parameters:
- Neurons_Layer1, 6, width of the position/percept vector (InVec).
- Neurons_Out, 2, output-layer neurons; index 0 = stay, index 1 = move.
- WINDOW, 64, clock cycles per spike-integration window.
- CNT_W, 8, spike counter width (saturating).
- MARGIN, 2, extra spikes move must lead stay by to win.
- MAX_STEPS, 16, decisions per trial before forced trial end.
- SETTLE, 4, cycles waited after a move before InVec is evaluated.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- active, in, 1, network running; low freezes the FSM in its current state.
- spike_out, in, Neurons_Out, output-layer spikes, one per cycle per neuron.
- InVec, in, Neurons_Layer1, current position vector fed back from the position generator.
- goal_vec, in, Neurons_Layer1, rewarded position; static during a trial.
- change_InVec, out, 1, one-cycle pulse requesting a position swap.
- trial_break, out, 1, one-cycle pulse ending the trial; drives the generator's break input.
- iTrial, out, 10, trial index.
- reward, out, 1, one-cycle pulse coincident with trial_break when the goal is reached.
- step_cnt, out, clog2(MAX_STEPS+1), decisions taken in the current trial.
- done, out, 1, sticky; high once iTrial saturates at 1023.

Behaviour:
- Reset (synchronous, active-high, single clock clk):
  - All outputs are 0; FSM goes to IDLE; counters clear.
  - Reset mid-window discards partial counts.
- FSM states: IDLE, INTEGRATE, DECIDE, MOVE, SETTLE, CHECK, TRIAL_END.
- IDLE:
  - Goes to INTEGRATE when active=1 and done=0.
  - Window counter and spike counters clear on entry.
- INTEGRATE:
  - Each cycle, cnt[i] += spike_out[i], saturating at 2^CNT_W-1.
  - After exactly WINDOW cycles, goes to DECIDE. The spike in the last window cycle is counted.
- DECIDE (1 cycle):
  - Compares cnt[1] > cnt[0] + MARGIN, with the sum computed at CNT_W+1 bits (no wrap).
  - True → MOVE. False → stay → CHECK.
  - step_cnt increments in both cases.
- MOVE (1 cycle):
  - change_InVec=1 for exactly this cycle.
  - Goes to SETTLE.
- SETTLE:
  - Waits SETTLE cycles for InVec to update, then goes to CHECK.
- CHECK (1 cycle):
  - InVec==goal_vec → TRIAL_END with reward.
  - Otherwise, step_cnt==MAX_STEPS → TRIAL_END without reward.
  - Otherwise → INTEGRATE, with counters cleared.
- TRIAL_END (1 cycle):
  - trial_break=1 and reward=(goal hit).
  - iTrial increments, saturating at 1023. On reaching 1023, done=1.
  - step_cnt clears; goes to IDLE.
- Pulse exclusivity:
  - change_InVec and trial_break are never high in the same cycle.
  - At least SETTLE+1 cycles separate any change_InVec from the next trial_break.
- active=0 in any state:
  - FSM, counters and the window timer hold; spikes are ignored.
  - Pulses do not repeat: a pulse state advances before the hold takes effect.
- done=1: stays in IDLE until reset.
- Latency: window start to change_InVec = WINDOW+2 cycles.

Optional Feature:
- EPSILON_EXPLORE_EN:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances every cycle.
  - In DECIDE, when LFSR[3:0]==0, the decision is inverted (1/16 exploration rate).
- Without the macro:
  - Decision is purely greedy; no LFSR logic is present.

Decomposition:
- Package hippo_ctrl_pkg holds:
  - the FSM state enum;
  - ACT_STAY=0 and ACT_MOVE=1;
  - ITRIAL_MAX=10'd1023;
  - LFSR_SEED and the tap constants.
- Sub-module spike_window_counter:
  - Per-neuron saturating counter with clear and enable.
  - Instantiated Neurons_Out times.

Test Plan:
- Move path: spike_out=2'b10 every cycle for the window (cnt1=64, cnt0=0), InVec==goal_vec after the move → change_InVec pulses at cycle 66; after SETTLE, trial_break=1, reward=1, iTrial 0→1.
- Tie/margin: cnt1=10, cnt0=8 (not > 8+2) → stay, no change_InVec, step_cnt=1; cnt1=11, cnt0=8 → move.
- Step limit: goal never matched, stay chosen every window → after 16 decisions trial_break=1, reward=0, step_cnt returns to 0.
- Saturation: spike_out=2'b11 for WINDOW=300 with CNT_W=8 → both counters hold at 255, stay chosen. Also preload iTrial=1022, end one trial → iTrial=1023, done=1, FSM stays in IDLE.
- active=0 for 20 cycles mid-INTEGRATE with spikes on both lines → counts unchanged; window completes 20 cycles late.
- Reset asserted in SETTLE → next cycle: all outputs 0, state IDLE, no late change_InVec or trial_break.

Source files
------------

// File: rtl/hippo_ctrl_pkg.sv
// Shared types and constants for the hippocampal agent control blocks.
package hippo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INTEGRATE = 3'd1,
    ST_DECIDE    = 3'd2,
    ST_MOVE      = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_CHECK     = 3'd5,
    ST_TRIAL_END = 3'd6
  } state_e;

  localparam logic ACT_STAY = 1'b0;
  localparam logic ACT_MOVE = 1'b1;

  localparam logic [9:0] ITRIAL_MAX = 10'd1023;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/action_decoder_if.sv
// Bundle between the SNN output layer / position generator and the action decoder.
interface action_decoder_if #(
  parameter int Neurons_Layer1 = 6,
  parameter int Neurons_Out    = 2,
  parameter int STEP_W         = 5
);
  logic                      active;
  logic [Neurons_Out-1:0]    spike_out;
  logic [Neurons_Layer1-1:0] InVec;
  logic [Neurons_Layer1-1:0] goal_vec;
  logic                      change_InVec;
  logic                      trial_break;
  logic [9:0]                iTrial;
  logic                      reward;
  logic [STEP_W-1:0]         step_cnt;
  logic                      done;

  modport master (
    output active, spike_out, InVec, goal_vec,
    input  change_InVec, trial_break, iTrial, reward, step_cnt, done
  );

  modport slave (
    input  active, spike_out, InVec, goal_vec,
    output change_InVec, trial_break, iTrial, reward, step_cnt, done
  );
endinterface

// File: rtl/spike_window_counter.sv
// Saturating per-neuron spike counter with synchronous clear and count enable.
module spike_window_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && spike && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/action_decoder.sv
// Spike-window action selector closing the SNN agent loop (stay/move, reward, trial limit).
// Optional EPSILON_EXPLORE_EN adds LFSR-driven 1/16 decision inversion.
module action_decoder
  import hippo_ctrl_pkg::*;
#(
  parameter int Neurons_Layer1 = 6,
  parameter int Neurons_Out    = 2,
  parameter int WINDOW         = 64,
  parameter int CNT_W          = 8,
  parameter int MARGIN         = 2,
  parameter int MAX_STEPS      = 16,
  parameter int SETTLE         = 4
) (
  input logic             clk,
  input logic             reset,
  action_decoder_if.slave bus
);

  // state        | meaning
  // IDLE         | waiting for active, counters cleared
  // INTEGRATE    | accumulating spikes for WINDOW active cycles
  // DECIDE       | move vs stay comparison, step_cnt++
  // MOVE         | change_InVec pulse
  // SETTLE       | wait SETTLE active cycles for InVec update
  // CHECK        | goal / step-limit evaluation
  // TRIAL_END    | trial_break (+reward) pulse, iTrial++

  localparam int STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CW1     = CNT_W + 1;

  state_e            state;
  logic [TMR_W-1:0]  tmr;
  logic [STEP_W-1:0] step_cnt;
  logic [9:0]        itrial;
  logic              done_r;
  logic              goal_hit;
  logic              cnt_clr;
  logic              cnt_en;
  logic              greedy_move;
  logic              act;
  logic [CNT_W-1:0]  cnt [Neurons_Out];

  assign cnt_en  = bus.active && (state == ST_INTEGRATE);
  assign cnt_clr = bus.active && ((state == ST_IDLE) || (state == ST_CHECK));

  for (genvar g = 0; g < Neurons_Out; g++) begin : g_cnt
    spike_window_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .spike (bus.spike_out[g]),
      .cnt   (cnt[g])
    );
  end

  // Extra bit keeps cnt[stay] + MARGIN from wrapping near saturation
  assign greedy_move = ({1'b0, cnt[ACT_MOVE]} > ({1'b0, cnt[ACT_STAY]} + CW1'(MARGIN)));

`ifdef EPSILON_EXPLORE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign act = greedy_move ^ (lfsr[3:0] == 4'd0);
`else
  assign act = greedy_move;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      step_cnt <= '0;
      itrial   <= '0;
      done_r   <= 1'b0;
      goal_hit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.active && !done_r) begin
            state <= ST_INTEGRATE;
            tmr   <= TMR_W'(WINDOW - 1);
          end
        end
        ST_INTEGRATE: begin
          if (bus.active) begin
            if (tmr == '0) state <= ST_DECIDE;
            else           tmr   <= tmr - TMR_W'(1);
          end
        end
        ST_DECIDE: begin
          if (bus.active) begin
            step_cnt <= step_cnt + STEP_W'(1);
            state    <= (act == ACT_MOVE) ? ST_MOVE : ST_CHECK;
          end
        end
        // Pulse states advance even when inactive so a pulse never repeats
        ST_MOVE: begin
          state <= ST_SETTLE;
          tmr   <= TMR_W'(SETTLE - 1);
        end
        ST_SETTLE: begin
          if (bus.active) begin
            if (tmr == '0) state <= ST_CHECK;
            else           tmr   <= tmr - TMR_W'(1);
          end
        end
        ST_CHECK: begin
          if (bus.active) begin
            if (bus.InVec == bus.goal_vec) begin
              goal_hit <= 1'b1;
              state    <= ST_TRIAL_END;
            end else if (step_cnt == STEP_W'(MAX_STEPS)) begin
              goal_hit <= 1'b0;
              state    <= ST_TRIAL_END;
            end else begin
              state <= ST_INTEGRATE;
              tmr   <= TMR_W'(WINDOW - 1);
            end
          end
        end
        ST_TRIAL_END: begin
          if (itrial != ITRIAL_MAX) itrial <= itrial + 10'd1;
          if (itrial >= ITRIAL_MAX - 10'd1) done_r <= 1'b1;
          step_cnt <= '0;
          goal_hit <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.change_InVec = (state == ST_MOVE);
  assign bus.trial_break  = (state == ST_TRIAL_END);
  assign bus.reward       = (state == ST_TRIAL_END) && goal_hit;
  assign bus.iTrial       = itrial;
  assign bus.step_cnt     = step_cnt;
  assign bus.done         = done_r;

endmodule
